sonar_ranger: RTL and testbench
===============================

Name: sonar_ranger

Overview:
- Memory-mapped ultrasonic ranging peripheral. It is the responder on the processor's data-memory bus, for addresses decoded in the I/O window.
- Processor stores a start command; block emits a trigger pulse on an I/O pin, times the echo pulse width in clock cycles, and exposes status/result for processor loads.
- Sits beside RAM in the top-level wrapper, sharing the processor clock. Trigger/echo connect to PINS.

Parameters:
- BASE_ADDR, 12'hF00: word address of CTRL register. STATUS = BASE_ADDR+1, RESULT = BASE_ADDR+2.
- TRIG_CYCLES, 500: trigger high time in clocks (10 us at 50 MHz).
- TIMEOUT_CYCLES, 1500000: max clocks waiting for echo rise, and max echo count.
- CNT_W, 32: counter/result width; must hold TIMEOUT_CYCLES.

Ports:
- clock  in  1  processor clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- wEn  in  1  store strobe from processor
- addr  in  12  word address from processor
- dataIn  in  32  store data
- dataOut  out  32  load data for matching addresses, 0 otherwise
- sel  out  1  high when addr hits CTRL/STATUS/RESULT (combinational; wrapper muxes dataOut vs RAM)
- trig  out  1  trigger pin to sensor
- echo  in  1  echo pin from sensor (asynchronous)
- busy  out  1  measurement in progress
- irq  out  1  one-cycle pulse when a measurement completes (valid or timeout)

Behaviour:
- Reset (async): state IDLE; trig=0, busy=0, irq=0, dataOut=0, RESULT=0, STATUS.valid=0, STATUS.timeout=0, counters=0, echo synchronizer=0.
- echo passes a 2-flop synchronizer before use; edge detect on synchronized value (2-cycle input latency).
- Write CTRL with wEn=1 and dataIn[0]=1 while IDLE or DONE: start. Clears valid/timeout, enters TRIG next edge. A start while busy is ignored. Writes to STATUS/RESULT are ignored.
- FSM:
  - IDLE: trig=0.
  - TRIG: trig=1 for exactly TRIG_CYCLES clocks, then WAIT_RISE with counter cleared.
  - WAIT_RISE: count clocks. Sync echo rise -> MEASURE with count=0. Count reaches TIMEOUT_CYCLES -> DONE with timeout=1, RESULT=0.
  - MEASURE: increment each cycle echo_sync=1. On fall -> DONE with RESULT=count, valid=1. Count reaching TIMEOUT_CYCLES -> DONE with RESULT=TIMEOUT_CYCLES, timeout=1 (saturate, no wrap).
  - DONE: irq high for the single cycle of entry; behaves as IDLE otherwise.
- busy=1 in TRIG, WAIT_RISE, MEASURE.
- Echo already high on entry to WAIT_RISE: no rise edge seen; waits for a fresh rise or timeout.
- Reads: dataOut registered, valid one cycle after addr presented (same as RAM latency).
  - CTRL reads {31'b0, busy}.
  - STATUS reads {29'b0, timeout, valid, busy}.
  - RESULT reads zero-extended RESULT.
- Read and completion in the same cycle: the read returns the pre-update value.
- Reset mid-measurement aborts immediately; trig drops asynchronously.

Optional Feature:
- Macro: SONAR_AUTO_REPEAT_EN.
- Defined: CTRL bit1 (repeat) is stored. While set, DONE automatically restarts TRIG after a holdoff of TIMEOUT_CYCLES clocks. RESULT/valid update each completion; irq pulses each time. Clearing bit1 stops after the current cycle. CTRL reads {30'b0, repeat, busy}.
- Not defined: bit1 is ignored and reads 0; single-shot only.

Test Plan (TRIG_CYCLES=10, TIMEOUT_CYCLES=1000):
- Reset, store 1 to CTRL: trig high exactly 10 cycles. Echo high 250 cycles after 40-cycle delay gives RESULT=250, STATUS=3'b010, one irq pulse.
- Start, echo never rises: DONE after 1000 wait cycles, STATUS=3'b100, RESULT=0, irq pulse.
- Echo held high 5000 cycles: RESULT=1000 (saturated), timeout=1, no wrap.
- Second start write during MEASURE: ignored, trig stays 0, result matches first echo. Load of RESULT at completion cycle returns old value, new value next load.
- Assert reset mid-TRIG: trig=0 and busy=0 within the same cycle. All registers read 0 afterwards.
- With SONAR_AUTO_REPEAT_EN, store 3 and drive echo 100 cycles each round: three irq pulses, RESULT=100 each. Store 0: stops after the current measurement.

Source files
------------

// File: rtl/sonar_ranger.sv
// rtl/sonar_ranger.sv - memory-mapped ultrasonic ranger: trigger pulse, echo width timing, status/result registers
// Optional macro SONAR_AUTO_REPEAT_EN: CTRL bit1 re-arms a new measurement after a holdoff.
module sonar_ranger #(
  parameter logic [11:0] BASE_ADDR      = 12'hF00,
  parameter int          TRIG_CYCLES    = 500,
  parameter int          TIMEOUT_CYCLES = 1500000,
  parameter int          CNT_W          = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wEn,
  input  logic [11:0] addr,
  input  logic [31:0] dataIn,
  output logic [31:0] dataOut,
  output logic        sel,
  output logic        trig,
  input  logic        echo,
  output logic        busy,
  output logic        irq
);

  localparam logic [11:0]      LP_STAT_ADDR = BASE_ADDR + 12'd1;
  localparam logic [11:0]      LP_RES_ADDR  = BASE_ADDR + 12'd2;
  localparam logic [CNT_W-1:0] LP_TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_TO_FULL   = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_RISE,
    S_MEASURE,
    S_DONE
  } state_t;

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic [CNT_W-1:0] r_result, w_result_nx;
  logic             r_valid, w_valid_nx;
  logic             r_timeout, w_timeout_nx;
  logic             r_trig, r_busy, r_irq;
  logic [31:0]      r_dout;
  logic             r_echo_s1, r_echo_s2, r_echo_s3;
  logic             w_ctrl_wr, w_start, w_rise, w_level, w_repeat;
  logic             w_unused_din;

  assign w_ctrl_wr = wEn && (addr == BASE_ADDR);
  assign w_start   = w_ctrl_wr && dataIn[0];
  // s3 is the edge-detect history; measuring on s3 lines the count up with the rise cycle
  assign w_rise    = r_echo_s2 & ~r_echo_s3;
  assign w_level   = r_echo_s3;

`ifdef SONAR_AUTO_REPEAT_EN
  logic r_repeat;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_repeat <= 1'b0;
    end else if (w_ctrl_wr) begin
      r_repeat <= dataIn[1];
    end
  end
  assign w_repeat     = r_repeat;
  assign w_unused_din = ^dataIn[31:2];
`else
  assign w_repeat     = 1'b0;
  assign w_unused_din = ^dataIn[31:1];
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_echo_s1 <= 1'b0;
      r_echo_s2 <= 1'b0;
      r_echo_s3 <= 1'b0;
    end else begin
      r_echo_s1 <= echo;
      r_echo_s2 <= r_echo_s1;
      r_echo_s3 <= r_echo_s2;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_result  <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_trig    <= 1'b0;
      r_busy    <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_cnt     <= w_cnt_nx;
      r_result  <= w_result_nx;
      r_valid   <= w_valid_nx;
      r_timeout <= w_timeout_nx;
      r_trig    <= (w_next == S_TRIG);
      r_busy    <= (w_next == S_TRIG) || (w_next == S_WAIT_RISE) || (w_next == S_MEASURE);
      r_irq     <= (w_next == S_DONE) && (r_state != S_DONE);
    end
  end

  always_comb begin
    w_next       = r_state;
    w_cnt_nx     = r_cnt;
    w_result_nx  = r_result;
    w_valid_nx   = r_valid;
    w_timeout_nx = r_timeout;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_start) begin
          w_next       = S_TRIG;
          w_cnt_nx     = '0;
          w_valid_nx   = 1'b0;
          w_timeout_nx = 1'b0;
        end else if ((r_state == S_DONE) && w_repeat) begin
          if (r_cnt == LP_TO_LAST) begin
            w_next       = S_TRIG;
            w_cnt_nx     = '0;
            w_valid_nx   = 1'b0;
            w_timeout_nx = 1'b0;
          end else begin
            w_cnt_nx = r_cnt + 1'b1;
          end
        end
      end
      S_TRIG: begin
        if (r_cnt == LP_TRIG_LAST) begin
          w_next   = S_WAIT_RISE;
          w_cnt_nx = '0;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      S_WAIT_RISE: begin
        if (w_rise) begin
          w_next   = S_MEASURE;
          w_cnt_nx = '0;
        end else if (r_cnt == LP_TO_LAST) begin
          w_next       = S_DONE;
          w_cnt_nx     = '0;
          w_result_nx  = '0;
          w_timeout_nx = 1'b1;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      S_MEASURE: begin
        if (!w_level) begin
          w_next      = S_DONE;
          w_cnt_nx    = '0;
          w_result_nx = r_cnt;
          w_valid_nx  = 1'b1;
        end else if (r_cnt == LP_TO_LAST) begin
          w_next       = S_DONE;
          w_cnt_nx     = '0;
          w_result_nx  = LP_TO_FULL;
          w_timeout_nx = 1'b1;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      default: begin
        w_next   = S_IDLE;
        w_cnt_nx = '0;
      end
    endcase
  end

  // Registered read port samples pre-update values, matching RAM load latency
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_dout <= '0;
    end else begin
      case (addr)
        BASE_ADDR:    r_dout <= {30'b0, w_repeat, r_busy};
        LP_STAT_ADDR: r_dout <= {29'b0, r_timeout, r_valid, r_busy};
        LP_RES_ADDR:  r_dout <= 32'(r_result);
        default:      r_dout <= '0;
      endcase
    end
  end

  assign sel     = (addr == BASE_ADDR) || (addr == LP_STAT_ADDR) || (addr == LP_RES_ADDR);
  assign dataOut = r_dout;
  assign trig    = r_trig;
  assign busy    = r_busy;
  assign irq     = r_irq;

endmodule

// File: tb/tb_sonar_ranger.sv
// tb/tb_sonar_ranger.sv - self-checking bench for sonar_ranger with vector table and random echo widths
module tb_sonar_ranger;

  localparam int TRIG = 10;
  localparam int TO   = 1000;
  localparam logic [11:0] CTRL_A = 12'hF00;
  localparam logic [11:0] STAT_A = 12'hF01;
  localparam logic [11:0] RES_A  = 12'hF02;

  logic        clock, reset, wEn, sel, trig, echo, busy, irq;
  logic [11:0] addr;
  logic [31:0] dataIn, dataOut;
  int          n_cmp = 0;
  int          n_fail = 0;

  sonar_ranger #(
    .BASE_ADDR(12'hF00), .TRIG_CYCLES(TRIG), .TIMEOUT_CYCLES(TO), .CNT_W(32)
  ) dut (
    .clock(clock), .reset(reset), .wEn(wEn), .addr(addr), .dataIn(dataIn),
    .dataOut(dataOut), .sel(sel), .trig(trig), .echo(echo), .busy(busy), .irq(irq)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d);
    addr = a;
    @(negedge clock);
    d = dataOut;
  endtask

  // Reference: the result is the echo width in clocks, clipped at the timeout; no rise means timeout with zero
  function automatic logic [31:0] model_result(input int wid);
    return (wid >= TO) ? TO : wid;
  endfunction
  function automatic logic [2:0] model_status(input int wid);
    return (wid >= TO) ? 3'b100 : 3'b010;
  endfunction

  task automatic run_meas(input int dly, input int wid, input bit pre_high, input int wr_k,
                          output int trig_hi, output int trig_late, output int irq_n, output int lat,
                          output logic [31:0] rd_at_irq, output logic [31:0] rd_after);
    trig_hi = 0; trig_late = 0; irq_n = 0; lat = -1; rd_at_irq = 'x; rd_after = 'x;
    echo = pre_high;
    addr = CTRL_A; dataIn = 32'd1; wEn = 1'b1;
    @(negedge clock);
    wEn = 1'b0; dataIn = '0; addr = RES_A;
    while (trig === 1'b1 && trig_hi < 100) begin
      trig_hi++;
      @(negedge clock);
    end
    for (int k = 0; k < 8000; k++) begin
      if (irq === 1'b1) begin
        irq_n++;
        if (lat < 0) begin
          lat = k;
          rd_at_irq = dataOut;
        end
      end
      if (lat >= 0 && k == lat + 1) rd_after = dataOut;
      if (trig === 1'b1) trig_late++;
      if (lat >= 0 && k > lat + 5) break;
      echo = pre_high || (dly >= 0 && k >= dly && k < dly + wid);
      if (k == wr_k) begin
        addr = CTRL_A; dataIn = 32'd1; wEn = 1'b1;
      end else begin
        addr = RES_A; dataIn = '0; wEn = 1'b0;
      end
      @(negedge clock);
    end
    echo = 1'b0;
  endtask

  typedef struct {
    int          dly;
    int          wid;
    bit          pre;
    int          wr_k;
    logic [31:0] exp_res;
    logic [2:0]  exp_stat;
    int          exp_lat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [31:0] d, r0, r1, prev_res, exp_r;
    logic [2:0]  exp_s;
    int          th, tl, ni, lat, rdly, rwid;
    logic [11:0] sel_addrs[5];
    logic        sel_exp[5];

    vecs[0] = '{40,   250,  1'b0, -1,  32'd250,  3'b010, -1};
    vecs[1] = '{-1,   0,    1'b0, -1,  32'd0,    3'b100, 1000};
    vecs[2] = '{5,    5000, 1'b0, -1,  32'd1000, 3'b100, -1};
    vecs[3] = '{0,    1,    1'b0, -1,  32'd1,    3'b010, -1};
    vecs[4] = '{3,    999,  1'b0, -1,  32'd999,  3'b010, -1};
    vecs[5] = '{3,    1000, 1'b0, -1,  32'd1000, 3'b100, -1};
    vecs[6] = '{-1,   0,    1'b1, -1,  32'd0,    3'b100, 1000};
    vecs[7] = '{40,   250,  1'b0, 100, 32'd250,  3'b010, -1};
    sel_addrs = '{12'hF00, 12'hF01, 12'hF02, 12'hF03, 12'hEFF};
    sel_exp   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    reset = 1'b1; wEn = 1'b0; addr = '0; dataIn = '0; echo = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_trig", trig, 0);
    check("rst_busy", busy, 0);
    check("rst_irq", irq, 0);
    check("rst_dout", dataOut, 0);
    check("rst_sel", sel, 0);
    reset = 1'b0;
    @(negedge clock);
    rd(CTRL_A, d); check("rst_ctrl", d, 0);
    rd(STAT_A, d); check("rst_stat", d, 0);
    rd(RES_A, d);  check("rst_res", d, 0);

    foreach (sel_addrs[i]) begin
      addr = sel_addrs[i];
      #1;
      check($sformatf("sel_%0h", sel_addrs[i]), sel, sel_exp[i]);
    end

    addr = STAT_A; dataIn = 32'd1; wEn = 1'b1;
    @(negedge clock);
    wEn = 1'b0; dataIn = '0; addr = RES_A;
    @(negedge clock);
    check("stat_wr_ignored_busy", busy, 0);
    check("stat_wr_ignored_trig", trig, 0);

    prev_res = '0;
    foreach (vecs[i]) begin
      run_meas(vecs[i].dly, vecs[i].wid, vecs[i].pre, vecs[i].wr_k, th, tl, ni, lat, r0, r1);
      check($sformatf("v%0d_trig_cycles", i), th, TRIG);
      check($sformatf("v%0d_trig_after", i), tl, 0);
      check($sformatf("v%0d_irq_pulses", i), ni, 1);
      if (vecs[i].exp_lat >= 0) check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_read_at_done", i), r0, prev_res);
      check($sformatf("v%0d_read_after", i), r1, vecs[i].exp_res);
      rd(STAT_A, d); check($sformatf("v%0d_status", i), d, {29'b0, vecs[i].exp_stat});
      rd(RES_A, d);  check($sformatf("v%0d_result", i), d, vecs[i].exp_res);
      prev_res = vecs[i].exp_res;
    end

    for (int i = 0; i < 6; i++) begin
      rdly = int'($urandom_range(0, 300));
      rwid = int'($urandom_range(1, 1100));
      exp_r = model_result(rwid);
      exp_s = model_status(rwid);
      run_meas(rdly, rwid, 1'b0, -1, th, tl, ni, lat, r0, r1);
      check($sformatf("rnd%0d_w%0d_irq", i, rwid), ni, 1);
      check($sformatf("rnd%0d_w%0d_read_at_done", i, rwid), r0, prev_res);
      rd(STAT_A, d); check($sformatf("rnd%0d_w%0d_status", i, rwid), d, {29'b0, exp_s});
      rd(RES_A, d);  check($sformatf("rnd%0d_w%0d_result", i, rwid), d, exp_r);
      prev_res = exp_r;
    end

    addr = CTRL_A; dataIn = 32'd1; wEn = 1'b1;
    @(negedge clock);
    wEn = 1'b0; dataIn = '0;
    repeat (3) @(negedge clock);
    check("pre_rst_trig", trig, 1);
    #2 reset = 1'b1;
    #1;
    check("midrst_trig", trig, 0);
    check("midrst_busy", busy, 0);
    check("midrst_dout", dataOut, 0);
    @(negedge clock);
    reset = 1'b0;
    rd(CTRL_A, d); check("post_rst_ctrl", d, 0);
    rd(STAT_A, d); check("post_rst_stat", d, 0);
    rd(RES_A, d);  check("post_rst_res", d, 0);

`ifdef SONAR_AUTO_REPEAT_EN
    begin : rep_blk
      int   irq_k, rounds, es, nirq;
      bit   clr;
      logic ptrig;
      irq_k = -1; rounds = 0; es = -1; nirq = 0; clr = 1'b0;
      addr = CTRL_A; dataIn = 32'd3; wEn = 1'b1;
      @(negedge clock);
      wEn = 1'b0; dataIn = '0; addr = CTRL_A;
      @(negedge clock);
      check("rep_ctrl_read", dataOut, 3);
      ptrig = trig;
      for (int k = 0; k < 7000; k++) begin
        if (irq === 1'b1) begin
          nirq++;
          irq_k = k;
        end
        if (irq_k >= 0 && k == irq_k + 1) check($sformatf("rep%0d_result", nirq), dataOut, 100);
        if (ptrig === 1'b1 && trig === 1'b0) begin
          rounds++;
          es = k + 10;
        end
        ptrig = trig;
        echo = (es >= 0 && k >= es && k < es + 100);
        if (rounds == 3 && !clr) begin
          clr = 1'b1; addr = CTRL_A; dataIn = '0; wEn = 1'b1;
        end else begin
          addr = RES_A; dataIn = '0; wEn = 1'b0;
        end
        @(negedge clock);
      end
      echo = 1'b0;
      check("rep_irq_count", nirq, 3);
      check("rep_rounds", rounds, 3);
      check("rep_idle_busy", busy, 0);
      rd(CTRL_A, d); check("rep_ctrl_cleared", d, 0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
